// File: rtl/disp_p2s_arbiter.sv
// Round-robin arbiter sharing one serial shift engine between the LED bar (ch0) and the 7-seg board (ch1).
// Optional feature macro: DISP_P2S_AUTO_REFRESH_EN (periodic re-send of each channel's last granted word).

module disp_p2s_arbiter #(
  parameter int W0             = 16,
  parameter int W1             = 64,
  parameter int DIV            = 2,
  parameter int MSB_FIRST      = 1,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [W0-1:0] data0,
  input  logic          req1,
  input  logic [W1-1:0] data1,
  output logic          ack0,
  output logic          ack1,
  output logic          busy,
  output logic          ch0_sclk,
  output logic          ch0_sout,
  output logic          ch0_en,
  output logic          ch1_sclk,
  output logic          ch1_sout,
  output logic          ch1_en
);

  localparam int WM = (W0 > W1) ? W0 : W1;
  localparam int CW = $clog2(2 * DIV + 1);
  localparam logic [CW-1:0] DIV_LO  = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_END = CW'(2 * DIV - 1);
  localparam logic [6:0]    W0_L    = 7'(W0);
  localparam logic [6:0]    W1_L    = 7'(W1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  if (W0 < 1 || W0 > 64 || W1 < 1 || W1 > 64 || DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("disp_p2s_arbiter: parameter out of range");
  end

  // Words are aligned so the bit to send is always at the same end of the shift register.
  function automatic logic [WM-1:0] align0(input logic [W0-1:0] d);
    logic [WM-1:0] x;
    x = WM'(d);
    if (MSB_FIRST != 0) x = x << (WM - W0);
    return x;
  endfunction

  function automatic logic [WM-1:0] align1(input logic [W1-1:0] d);
    logic [WM-1:0] x;
    x = WM'(d);
    if (MSB_FIRST != 0) x = x << (WM - W1);
    return x;
  endfunction

  function automatic logic head_bit(input logic [WM-1:0] x);
    return (MSB_FIRST != 0) ? x[WM-1] : x[0];
  endfunction

  logic [1:0]    state, state_n;
  logic          sel, sel_n, last, last_n, refr, refr_n;
  logic [WM-1:0] shreg, shreg_n, sh_adv, gnt_word;
  logic [6:0]    bits, bits_n;
  logic [CW-1:0] div_cnt, div_n;
  logic          sclk, sclk_n, sout, sout_n, en, en_n, ack0_n, ack1_n;
  logic          gnt, gnt_ch, gnt_ref, take;
  logic [W0-1:0] src0;
  logic [W1-1:0] src1;

`ifdef DISP_P2S_AUTO_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RCW-1:0] R_END = RCW'(REFRESH_CYCLES - 1);

  logic [RCW-1:0] rcnt;
  logic           flag0, flag1, expire;
  logic [W0-1:0]  keep0;
  logic [W1-1:0]  keep1;

  assign expire = (rcnt == R_END);

  // A real grant also satisfies that channel's pending refresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt  <= '0;
      flag0 <= 1'b0;
      flag1 <= 1'b0;
      keep0 <= '0;
      keep1 <= '0;
    end else begin
      rcnt <= expire ? '0 : rcnt + 1'b1;
      if (expire) flag0 <= 1'b1;
      else if (take && !gnt_ch) flag0 <= 1'b0;
      if (expire) flag1 <= 1'b1;
      else if (take && gnt_ch) flag1 <= 1'b0;
      if (take && !gnt_ref && !gnt_ch) keep0 <= data0;
      if (take && !gnt_ref && gnt_ch) keep1 <= data1;
    end
  end
`endif

  assign take = (state == IDLE) && gnt;

  always_comb begin
    gnt     = 1'b0;
    gnt_ch  = 1'b0;
    gnt_ref = 1'b0;
    src0    = data0;
    src1    = data1;
    if (req0 || req1) begin
      gnt    = 1'b1;
      gnt_ch = req1 && (!req0 || !last);
    end
`ifdef DISP_P2S_AUTO_REFRESH_EN
    else if (flag0 || flag1) begin
      gnt     = 1'b1;
      gnt_ref = 1'b1;
      gnt_ch  = flag1 && (!flag0 || !last);
      src0    = keep0;
      src1    = keep1;
    end
`endif
    gnt_word = gnt_ch ? align1(src1) : align0(src0);
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    refr_n  = refr;
    shreg_n = shreg;
    bits_n  = bits;
    div_n   = div_cnt;
    sclk_n  = sclk;
    sout_n  = sout;
    en_n    = en;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    sh_adv  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    case (state)
      IDLE: begin
        sclk_n = 1'b0;
        sout_n = 1'b0;
        en_n   = 1'b0;
        if (gnt) begin
          state_n = SHIFT;
          sel_n   = gnt_ch;
          last_n  = gnt_ch;
          refr_n  = gnt_ref;
          shreg_n = gnt_word;
          bits_n  = gnt_ch ? W1_L : W0_L;
          div_n   = '0;
          sout_n  = head_bit(gnt_word);
        end
      end
      // Each bit spans DIV low then DIV high cycles; the falling edge moves on.
      SHIFT: begin
        if (div_cnt == DIV_END) begin
          div_n  = '0;
          sclk_n = 1'b0;
          if (bits == 7'd1) begin
            state_n = LATCH;
            sout_n  = 1'b0;
            en_n    = 1'b1;
          end else begin
            shreg_n = sh_adv;
            sout_n  = head_bit(sh_adv);
            bits_n  = bits - 1'b1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
          if (div_cnt == DIV_LO) sclk_n = 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LO) begin
          div_n   = '0;
          en_n    = 1'b0;
          state_n = DONE;
          ack0_n  = !refr && !sel;
          ack1_n  = !refr && sel;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      refr     <= 1'b0;
      shreg    <= '0;
      bits     <= '0;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      sout     <= 1'b0;
      en       <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      ch0_sclk <= 1'b0;
      ch0_sout <= 1'b0;
      ch0_en   <= 1'b0;
      ch1_sclk <= 1'b0;
      ch1_sout <= 1'b0;
      ch1_en   <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      last     <= last_n;
      refr     <= refr_n;
      shreg    <= shreg_n;
      bits     <= bits_n;
      div_cnt  <= div_n;
      sclk     <= sclk_n;
      sout     <= sout_n;
      en       <= en_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      busy     <= (state_n != IDLE);
      ch0_sclk <= sclk_n && !sel_n;
      ch0_sout <= sout_n && !sel_n;
      ch0_en   <= en_n && !sel_n;
      ch1_sclk <= sclk_n && sel_n;
      ch1_sout <= sout_n && sel_n;
      ch1_en   <= en_n && sel_n;
    end
  end

endmodule

// File: tb/tb_disp_p2s_arbiter.sv
// Directed bench for disp_p2s_arbiter: one MSB-first instance and one LSB-first instance on shared stimulus.

module tb_disp_p2s_arbiter;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic [15:0] data0 = '0;
  logic [63:0] data1 = '0;

  logic ack0, ack1, busy, ch0_sclk, ch0_sout, ch0_en, ch1_sclk, ch1_sout, ch1_en;
  logic b_ack0, b_ack1, b_busy, b_ch0_sclk, b_ch0_sout, b_ch0_en, b_ch1_sclk, b_ch1_sout, b_ch1_en;

  int checks = 0;
  int errors = 0;
  int cnt[9] = '{default: 0};
  int base[9] = '{default: 0};
  int d[9] = '{default: 0};
  logic [63:0] cap0 = '0, cap1 = '0, bcap1 = '0;
  logic p0 = 1'b0, p1 = 1'b0, bp1 = 1'b0;
  int lat;

  always #5 clk = ~clk;

  disp_p2s_arbiter #(.W0(16), .W1(64), .DIV(2), .MSB_FIRST(1), .REFRESH_CYCLES(500)) dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .ch0_sclk(ch0_sclk), .ch0_sout(ch0_sout), .ch0_en(ch0_en),
    .ch1_sclk(ch1_sclk), .ch1_sout(ch1_sout), .ch1_en(ch1_en)
  );

  disp_p2s_arbiter #(.W0(16), .W1(64), .DIV(2), .MSB_FIRST(0), .REFRESH_CYCLES(500)) dut_lsb (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(b_ack0), .ack1(b_ack1), .busy(b_busy),
    .ch0_sclk(b_ch0_sclk), .ch0_sout(b_ch0_sout), .ch0_en(b_ch0_en),
    .ch1_sclk(b_ch1_sclk), .ch1_sout(b_ch1_sout), .ch1_en(b_ch1_en)
  );

  // Counters: 0 ch0 bits, 1 ch1 bits, 2 lsb ch1 bits, 3 ch0 en cycles, 4 ack0, 5 ack1,
  // 6 ch0 pin activity, 7 ch1 pin activity, 8 cycles.
  always @(negedge clk) begin
    if (ch0_sclk && !p0) begin cap0 = {cap0[62:0], ch0_sout}; cnt[0]++; end
    if (ch1_sclk && !p1) begin cap1 = {cap1[62:0], ch1_sout}; cnt[1]++; end
    if (b_ch1_sclk && !bp1) begin bcap1 = {bcap1[62:0], b_ch1_sout}; cnt[2]++; end
    p0  = ch0_sclk;
    p1  = ch1_sclk;
    bp1 = b_ch1_sclk;
    if (ch0_en) cnt[3]++;
    if (ack0) cnt[4]++;
    if (ack1) cnt[5]++;
    if (ch0_sclk || ch0_sout || ch0_en) cnt[6]++;
    if (ch1_sclk || ch1_sout || ch1_en) cnt[7]++;
    cnt[8]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({busy, ack0, ack1, ch0_sclk, ch0_sout, ch0_en, ch1_sclk, ch1_sout, ch1_en});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({b_busy, b_ack0, b_ack1, b_ch0_sclk, b_ch0_sout, b_ch0_en, b_ch1_sclk, b_ch1_sout, b_ch1_en});
  endfunction

  task automatic snap();
    @(posedge clk);
    for (int i = 0; i < 9; i++) base[i] = cnt[i];
  endtask

  task automatic measure();
    @(posedge clk);
    for (int i = 0; i < 9; i++) d[i] = cnt[i] - base[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns with lat = cycles from the first busy cycle to the ack cycle.
  task automatic wait_ack(input bit ch, output int l);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!busy && t < 400);
    l = 0;
    while (!(ch ? ack1 : ack0) && l < 600) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit got;
    repeat (3) @(negedge clk);
    chk("reset_outs_msb", outs_a(), 64'd0);
    chk("reset_outs_lsb", outs_b(), 64'd0);

`ifdef DISP_P2S_AUTO_REFRESH_EN
    rst   = 1'b1;
    data0 = 16'h1234;
    req0  = 1'b1;
    snap();
    wait_ack(1'b0, lat);
    req0 = 1'b0;
    chk("rf_real_lat", 64'(lat), 64'd66);
    t = 0;
    while ((cnt[8] - base[8]) < 490 && t < 1000) begin @(posedge clk); t++; end
    @(negedge clk);
    data1 = 64'h0000_0000_0000_00FF;
    req1  = 1'b1;
    wait_ack(1'b1, lat);
    req1 = 1'b0;
    chk("rf_req1_first_lat", 64'(lat), 64'd258);
    snap();
    t = 0;
    do begin @(negedge clk); t++; end while (!busy && t < 50);
    chk("rf_refresh_started", 64'(busy), 64'd1);
    while (busy && t < 500) begin @(negedge clk); t++; end
    measure();
    chk("rf_ch0_bits", 64'(d[0]), 64'd16);
    chk("rf_ch0_word", 64'(cap0[15:0]), 64'h1234);
    chk("rf_no_ack0", 64'(d[4]), 64'd0);
    chk("rf_no_ack1", 64'(d[5]), 64'd0);
    chk("rf_ch1_quiet", 64'(d[7]), 64'd0);
`else
    // Single ch0 transfer, MSB first.
    rst   = 1'b1;
    data0 = 16'hA5F0;
    req0  = 1'b1;
    snap();
    wait_ack(1'b0, lat);
    req0 = 1'b0;
    measure();
    chk("t1_ack_latency", 64'(lat), 64'd66);
    chk("t1_bit_count", 64'(d[0]), 64'd16);
    chk("t1_word", 64'(cap0[15:0]), 64'hA5F0);
    chk("t1_en_cycles", 64'(d[3]), 64'd2);
    chk("t1_ack0_count", 64'(d[4]), 64'd1);
    chk("t1_ack1_count", 64'(d[5]), 64'd0);
    chk("t1_ch1_quiet", 64'(d[7]), 64'd0);

    // Simultaneous requests held: ch0 first after reset, then alternation.
    do_reset();
    data0 = 16'h3C5A;
    data1 = 64'hFEDC_BA98_7654_3210;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!(ack0 || ack1) && t < 1000) begin @(negedge clk); t++; end
      got = ack1;
      chk($sformatf("t2_order_%0d", k), 64'(got), 64'(k % 2));
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("t2_idle_gap_%0d", k), 64'(busy), 64'd0);
      if (k < 3) begin
        @(negedge clk);
        chk($sformatf("t2_regrant_%0d", k), 64'(busy), 64'd1);
      end
    end

    // 64-bit ch1, data changed mid-shift; LSB-first instance checked too.
    do_reset();
    data1 = 64'h0123_4567_89AB_CDEF;
    req1  = 1'b1;
    snap();
    repeat (40) @(negedge clk);
    data1 = 64'hFFFF_0000_FFFF_0000;
    wait_ack(1'b1, lat);
    req1 = 1'b0;
    measure();
    chk("t3_lsb_bits", 64'(d[2]), 64'd64);
    chk("t3_lsb_stream", bcap1, 64'hF7B3_D591_E6A2_C480);
    chk("t3_lsb_first_bit", 64'(bcap1[63]), 64'd1);
    chk("t3_lsb_last_bit", 64'(bcap1[0]), 64'd0);
    chk("t3_msb_stream", cap1, 64'h0123_4567_89AB_CDEF);

    // Reset mid-transfer aborts; held request restarts from bit 0.
    do_reset();
    data1 = 64'hDEAD_BEEF_0BAD_F00D;
    req1  = 1'b1;
    snap();
    t = 0;
    while ((cnt[1] - base[1]) < 20 && t < 2000) begin @(posedge clk); t++; end
    @(negedge clk);
    chk("t4_busy_before_abort", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("t4_async_clear", outs_a(), 64'd0);
    repeat (3) @(negedge clk);
    measure();
    chk("t4_no_ack1", 64'(d[5]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    snap();
    wait_ack(1'b1, lat);
    req1 = 1'b0;
    measure();
    chk("t4_restart_latency", 64'(lat), 64'd258);
    chk("t4_restart_bits", 64'(d[1]), 64'd64);
    chk("t4_restart_word", cap1, 64'hDEAD_BEEF_0BAD_F00D);

    // One-cycle req0 pulse while busy is never served.
    @(negedge clk);
    snap();
    data1 = 64'h5555_AAAA_5555_AAAA;
    req1  = 1'b1;
    repeat (10) @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    wait_ack(1'b1, lat);
    req1 = 1'b0;
    repeat (300) @(negedge clk);
    measure();
    chk("t5_ack1_count", 64'(d[5]), 64'd1);
    chk("t5_no_ack0", 64'(d[4]), 64'd0);
    chk("t5_ch0_quiet", 64'(d[6]), 64'd0);
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
